// File: rtl/spi_pkg.sv
// Shared state encoding and SPI mode constants for the parameterised SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } spi_state_e;

  // Modes are encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: tick pulses once every CLK_DIV cycles; clr restarts the count.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master_param.sv
// Parameterised SPI master: one DATA_W-bit MSB-first frame per accept, runtime CPOL/CPHA.
// Define SPI_LOOPBACK_EN to capture from the internal SDO bit instead of SPI_SDI.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W  = 60,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic              SPI_CLK,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              cpol,
  input  logic              cpha,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              SCLK,
  output logic              CSB,
  output logic              SPI_SDO,
  input  logic              SPI_SDI
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int GW = $clog2(CS_GAP + 1);

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              cpol_q, cpol_d, cpha_q, cpha_d;
  logic              lead_q, lead_d;  // next SCLK toggle is a leading edge
  logic              sclk_q, sclk_d, csb_q, csb_d, sdo_q, sdo_d;
  logic              rdy_q, rdy_d, rxv_q, rxv_d;
  logic              accept, tick, cap_bit;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk (SPI_CLK),
    .rst (reset),
    .clr (accept),
    .tick(tick)
  );

  assign accept = (state_q == IDLE) && tx_valid && rdy_q;

`ifdef SPI_LOOPBACK_EN
  logic unused_sdi;
  assign unused_sdi = SPI_SDI;
  assign cap_bit    = sdo_q;
`else
  assign cap_bit    = SPI_SDI;
`endif

  always_comb begin
    state_d   = state_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    bit_d     = bit_q;
    gap_d     = gap_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lead_d    = lead_q;
    sclk_d    = sclk_q;
    csb_d     = csb_q;
    sdo_d     = sdo_q;
    rxv_d     = 1'b0;
    case (state_q)
      IDLE: begin
        sclk_d = cpol_q;
        csb_d  = 1'b1;
        if (accept) begin
          cpol_d  = cpol;
          cpha_d  = cpha;
          sclk_d  = cpol;
          csb_d   = 1'b0;
          lead_d  = 1'b1;
          bit_d   = '0;
          rx_sh_d = '0;
          // CPHA=0 needs the MSB on the wire before the first (sampling) edge
          if (cpha) begin
            tx_sh_d = tx_data;
            sdo_d   = 1'b0;
          end else begin
            tx_sh_d = tx_data << 1;
            sdo_d   = tx_data[DATA_W-1];
          end
          state_d = SETUP;
        end
      end
      SETUP: if (tick) state_d = XFER;
      XFER: if (tick) begin
        sclk_d = ~sclk_q;
        lead_d = ~lead_q;
        if (lead_q ^ cpha_q) begin
          rx_sh_d = (rx_sh_q << 1) | DATA_W'(cap_bit);
        end else begin
          sdo_d   = tx_sh_q[DATA_W-1];
          tx_sh_d = tx_sh_q << 1;
        end
        if (!lead_q) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == BW'(DATA_W - 1)) state_d = HOLD;
        end
      end
      HOLD: if (tick) begin
        csb_d     = 1'b1;
        sdo_d     = 1'b0;
        rx_data_d = rx_sh_q;
        rxv_d     = 1'b1;
        gap_d     = '0;
        state_d   = GAP;
      end
      GAP: if (tick) begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GW'(CS_GAP - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge SPI_CLK or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      bit_q     <= '0;
      gap_q     <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lead_q    <= 1'b1;
      sclk_q    <= 1'b0;
      csb_q     <= 1'b1;
      sdo_q     <= 1'b0;
      rdy_q     <= 1'b0;
      rxv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      bit_q     <= bit_d;
      gap_q     <= gap_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      lead_q    <= lead_d;
      sclk_q    <= sclk_d;
      csb_q     <= csb_d;
      sdo_q     <= sdo_d;
      rdy_q     <= rdy_d;
      rxv_q     <= rxv_d;
    end
  end

  assign tx_ready = rdy_q;
  assign rx_valid = rxv_q;
  assign rx_data  = rx_data_q;
  assign SCLK     = sclk_q;
  assign CSB      = csb_q;
  assign SPI_SDO  = sdo_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Scoreboard bench: a 60-bit master with SDO fed back to SDI, and an 8-bit master against a slave model.
module tb_spi_master_param;
  import spi_pkg::*;

  localparam int W       = 60;
  localparam int WB      = 8;
  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // 60-bit instance
  logic [W-1:0] tx_a = '0, rxd_a;
  logic txv_a = 1'b0, txr_a, rxv_a, sclk_a, csb_a, sdo_a, sdi_a;
  logic cpol_a = 1'b0, cpha_a = 1'b0, tie0_a = 1'b0;
  assign sdi_a = tie0_a ? 1'b0 : sdo_a;

  spi_master_param #(.DATA_W(W), .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) u_dut_a (
    .SPI_CLK(clk), .reset(rst), .tx_data(tx_a), .tx_valid(txv_a), .tx_ready(txr_a),
    .cpol(cpol_a), .cpha(cpha_a), .rx_data(rxd_a), .rx_valid(rxv_a),
    .SCLK(sclk_a), .CSB(csb_a), .SPI_SDO(sdo_a), .SPI_SDI(sdi_a)
  );

  // 8-bit instance
  logic [WB-1:0] tx_b = '0, rxd_b;
  logic txv_b = 1'b0, txr_b, rxv_b, sclk_b, csb_b, sdo_b;
  logic cpol_b = 1'b0, cpha_b = 1'b0, sdi_b = 1'b0;

  spi_master_param #(.DATA_W(WB), .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) u_dut_b (
    .SPI_CLK(clk), .reset(rst), .tx_data(tx_b), .tx_valid(txv_b), .tx_ready(txr_b),
    .cpol(cpol_b), .cpha(cpha_b), .rx_data(rxd_b), .rx_valid(rxv_b),
    .SCLK(sclk_b), .CSB(csb_b), .SPI_SDO(sdo_b), .SPI_SDI(sdi_b)
  );

  logic [W-1:0]  sb_a[$];
  logic [WB-1:0] sb_b[$];

  // Slave model: returns 8'h3C, captures master data, honours cpol/cpha
  logic [WB-1:0] s_tx = '0, s_rx = '0;
  bit s_act = 0, s_prev = 0;
  always @(negedge clk) begin
    if (csb_b) s_act = 0;
    else if (!s_act) begin
      s_act = 1;
      s_rx  = '0;
      s_tx  = 8'h3C;
      if (!cpha_b) begin sdi_b = s_tx[WB-1]; s_tx = s_tx << 1; end
      else sdi_b = 1'b0;
    end else if (sclk_b != s_prev) begin
      if ((sclk_b != cpol_b) ^ cpha_b) s_rx = {s_rx[WB-2:0], sdo_b};
      else begin sdi_b = s_tx[WB-1]; s_tx = s_tx << 1; end
    end
    s_prev = sclk_b;
  end

  // Monitor A: scoreboard pop, pulse width, CSB low/high timing, SCLK rising edges
  int rxv_cnt_a = 0, lo_cnt = 0, hi_cnt = 0, rises = 0;
  bit csb_prev = 1, sclk_prev = 0, rxv_prev_a = 0, csb_chk = 1, gap_chk = 0;
  always @(negedge clk) begin
    if (rxv_prev_a) chk("rxv_a_width", rxv_a, 0);
    if (rxv_a) begin
      rxv_cnt_a++;
      if (sb_a.size() == 0) chk("rx_a_unexpected", rxv_a, 0);
      else chk("rx_a", rxd_a, sb_a.pop_front());
    end
    if (!csb_a) begin
      if (csb_prev) begin
        if (gap_chk) chk("csb_gap", hi_cnt, CS_GAP*CLK_DIV+1);
        lo_cnt = 0;
        rises  = 0;
      end
      lo_cnt++;
      if (sclk_a && !sclk_prev) rises++;
    end else begin
      if (!csb_prev) begin
        if (csb_chk) begin
          chk("csb_low", lo_cnt, (2*W+2)*CLK_DIV);
          chk("sclk_rises", rises, W);
        end
        hi_cnt = 0;
      end
      hi_cnt++;
    end
    csb_prev   = csb_a;
    sclk_prev  = sclk_a;
    rxv_prev_a = rxv_a;
  end

  // Monitor B
  int rxv_cnt_b = 0;
  bit rxv_prev_b = 0;
  always @(negedge clk) begin
    if (rxv_prev_b) chk("rxv_b_width", rxv_b, 0);
    if (rxv_b) begin
      rxv_cnt_b++;
      if (sb_b.size() == 0) chk("rx_b_unexpected", rxv_b, 0);
      else chk("rx_b", rxd_b, sb_b.pop_front());
      chk("slave_rx", s_rx, 8'hA5);
      chk("idle_sclk", sclk_b, cpol_b);
    end
    rxv_prev_b = rxv_b;
  end

  task automatic send_a(input logic [W-1:0] d, input logic [W-1:0] exp, input bit keep);
    int t;
    t = 0;
    tx_a  = d;
    txv_a = 1'b1;
    sb_a.push_back(exp);
    while (!txr_a && t < 5000) begin @(negedge clk); t++; end
    if (!txr_a) chk("send_a_timeout", txr_a, 1);
    @(posedge clk);
    #1;
    if (!keep) txv_a = 1'b0;
  endtask

  task automatic send_b(input logic [WB-1:0] d, input logic [WB-1:0] exp);
    int t;
    t = 0;
    tx_b  = d;
    txv_b = 1'b1;
    sb_b.push_back(exp);
    while (!txr_b && t < 5000) begin @(negedge clk); t++; end
    if (!txr_b) chk("send_b_timeout", txr_b, 1);
    @(posedge clk);
    #1;
    txv_b = 1'b0;
  endtask

  task automatic wait_rx_a(input int target);
    int t;
    t = 0;
    while (rxv_cnt_a < target && t < 5000) begin @(negedge clk); t++; end
    #1;
    chk("rx_a_count", rxv_cnt_a, target);
  endtask

  task automatic wait_rx_b(input int target);
    int t;
    t = 0;
    while (rxv_cnt_b < target && t < 5000) begin @(negedge clk); t++; end
    #1;
    chk("rx_b_count", rxv_cnt_b, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    mt [4];
    logic [WB-1:0] exp_b;
    logic [W-1:0]  exp6;
    int cnt0;
    mt = '{MODE0, MODE1, MODE2, MODE3};

    // 1: reset state and tx_ready timing
    #100;
    chk("rst_csb", csb_a, 1);
    chk("rst_sclk", sclk_a, 0);
    chk("rst_sdo", sdo_a, 0);
    chk("rst_rxv", rxv_a, 0);
    chk("rst_rdy", txr_a, 0);
    chk("rst_rxd", rxd_a, 0);
    #100;
    rst = 1'b0;
    #1;
    chk("rdy_pre", txr_a, 0);
    @(posedge clk);
    #1;
    chk("rdy_post", txr_a, 1);

    // 2: mode 0, SDO looped to SDI externally
    send_a(60'h0123456789ABCDE, 60'h0123456789ABCDE, 0);
    wait_rx_a(1);

    // 3: all four modes against the 8-bit slave model
`ifdef SPI_LOOPBACK_EN
    exp_b = 8'hA5;
`else
    exp_b = 8'h3C;
`endif
    for (int i = 0; i < 4; i++) begin
      {cpol_b, cpha_b} = mt[i];
      send_b(8'hA5, exp_b);
      wait_rx_b(i + 1);
    end

    // 4: tx_valid held across three back-to-back frames
    send_a(60'h111111111111111, 60'h111111111111111, 1);
    @(negedge clk);
    #1;
    gap_chk = 1;
    send_a(60'h2222222222222AB, 60'h2222222222222AB, 1);
    send_a(60'h3CCCCCCCCCCCC33, 60'h3CCCCCCCCCCCC33, 0);
    wait_rx_a(4);
    gap_chk = 0;

    // 5: reset mid-frame, then a clean frame
    csb_chk = 0;
    send_a(60'hDEADBEEF0000001, 60'hDEADBEEF0000001, 0);
    repeat (2*CLK_DIV*31) @(posedge clk);
    #2;
    chk("mid_csb_low", csb_a, 0);
    cnt0 = rxv_cnt_a;
    rst  = 1'b1;
    #1;
    chk("rst_mid_csb", csb_a, 1);
    sb_a.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("rst_no_rxv", rxv_cnt_a, cnt0);
    csb_chk = 1;
    send_a(60'hFFF000FFF000FFF, 60'hFFF000FFF000FFF, 0);
    wait_rx_a(cnt0 + 1);

    // 6: SDI tied low; capture depends on whether loopback is built in
    tie0_a = 1'b1;
`ifdef SPI_LOOPBACK_EN
    exp6 = 60'hA5A5A5A5A5A5A5A;
`else
    exp6 = '0;
`endif
    send_a(60'hA5A5A5A5A5A5A5A, exp6, 0);
    wait_rx_a(cnt0 + 2);

    repeat (20) @(negedge clk);
    chk("sb_a_empty", sb_a.size(), 0);
    chk("sb_b_empty", sb_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
